// File: rtl/dcache_result_checker.sv
// Snoops D-cache writes into an answer window and scores them against a loadable golden table.
// Optional cycle-limit watchdog enabled by defining CHECKER_TIMEOUT_EN.
module dcache_result_checker #(
   parameter int              ADDR_W   = 30,
   parameter int              DATA_W   = 32,
   parameter int              NUM_ANS  = 16,
   parameter logic [ADDR_W-1:0] ANS_BASE = 30'h0000_0040,
   parameter int              ERR_W    = 8,
   parameter int              DUR_W    = 16,
   parameter int              TIMEOUT  = 10000,
   localparam int             IDX_W    = $clog2(NUM_ANS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wen,
   input  logic              gold_we,
   input  logic [IDX_W-1:0]  gold_idx,
   input  logic [DATA_W-1:0] gold_data,
   output logic [ERR_W-1:0]  error_num,
   output logic [DUR_W-1:0]  duration,
   output logic              finish,
   output logic              timeout,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_gold [NUM_ANS];
   logic [NUM_ANS-1:0]  r_seen;
   logic [ERR_W-1:0]    r_err;
   logic [DUR_W-1:0]    r_dur;
   logic                r_finish;

   logic [ADDR_W:0]     w_off;
   logic                w_hit;
   logic [IDX_W-1:0]    w_idx;
   logic                w_active;
   logic                w_chk;
   logic                w_mis;
   logic [NUM_ANS-1:0]  w_seen_nxt;
   logic                w_all;
   logic                w_tlim;

   // Offset is computed one bit wider so the upper window bound cannot wrap.
   assign w_off      = {1'b0, addr} - {1'b0, ANS_BASE};
   assign w_hit      = wen && (addr >= ANS_BASE) && (w_off < (ADDR_W+1)'(NUM_ANS));
   assign w_idx      = w_off[IDX_W-1:0];
   assign w_active   = (r_state != S_DONE);
   assign w_chk      = w_hit && w_active;
   assign w_mis      = (r_gold[w_idx] != wdata);
   assign w_seen_nxt = r_seen | (w_chk ? (NUM_ANS'(1) << w_idx) : '0);
   assign w_all      = &w_seen_nxt;

   // Golden table survives reset so a run can be restarted without reloading.
   always_ff @(posedge clk) begin
      if (gold_we) r_gold[gold_idx] <= gold_data;
   end

`ifdef CHECKER_TIMEOUT_EN
   logic [31:0] r_tcnt;
   logic        r_timeout;

   assign w_tlim  = (r_tcnt + 32'd1 == 32'(TIMEOUT));
   assign timeout = r_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
      end else if (w_active) begin
         r_tcnt <= r_tcnt + 32'd1;
         if (w_tlim && !w_all) r_timeout <= 1'b1;
      end
   end
`else
   assign w_tlim  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_seen   <= '0;
         r_err    <= '0;
         r_dur    <= '0;
         r_finish <= 1'b0;
      end else if (w_active) begin
         if (r_dur != '1) r_dur <= r_dur + DUR_W'(1);
         if (w_chk) begin
            r_seen <= w_seen_nxt;
            if (w_mis && (r_err != '1)) r_err <= r_err + ERR_W'(1);
         end
         // Completion takes precedence over the watchdog on the same edge.
         if (w_all) begin
            r_state  <= S_DONE;
            r_finish <= 1'b1;
         end else if (w_tlim) begin
            r_state  <= S_DONE;
         end else if (w_chk) begin
            r_state  <= S_RUN;
         end
      end
   end

   assign error_num = r_err;
   assign duration  = r_dur;
   assign finish    = r_finish;
   assign state     = r_state;

endmodule
